// File: rtl/axonerve_kvs_cmd_issuer.sv
// Request front end for the AXONERVE KVS kernel: decodes opcode requests into one-hot command
// strobes under a kernel-ready / FIFO-full / outstanding-window throttle.
// Optional statistics counters are built when AXONERVE_KVS_ISSUER_STATS_EN is defined.
module axonerve_kvs_cmd_issuer #(
   parameter int unsigned MAX_OUTSTANDING = 16,
   parameter int unsigned CNT_W           = 32
) (
   input  logic             I_CLK,
   input  logic             I_RST,
   input  logic             I_REQ_VALID,
   output logic             O_REQ_READY,
   input  logic [2:0]       I_REQ_OP,
   input  logic [127:0]     I_REQ_KEY,
   input  logic [127:0]     I_REQ_MSK,
   input  logic [6:0]       I_REQ_PRI,
   input  logic [31:0]      I_REQ_VALUE,
   input  logic             I_FLUSH,
   output logic             O_FLUSH_DONE,
   input  logic             I_KRN_READY,
   input  logic             I_KRN_WAIT,
   input  logic             I_KRN_CMD_FULL,
   input  logic             I_KRN_ACK,
   output logic             O_CMD_VALID,
   output logic             O_CMD_ERASE,
   output logic             O_CMD_WRITE,
   output logic             O_CMD_READ,
   output logic             O_CMD_SEARCH,
   output logic             O_CMD_UPDATE,
   output logic [127:0]     O_KEY_DAT,
   output logic [127:0]     O_EKEY_MSK,
   output logic [6:0]       O_KEY_PRI,
   output logic [31:0]      O_KEY_VALUE,
   output logic [7:0]       O_OUTSTANDING,
   output logic             O_ACK_UNDERFLOW,
   output logic [CNT_W-1:0] O_ISSUE_CNT,
   output logic [CNT_W-1:0] O_ACK_CNT,
   output logic [CNT_W-1:0] O_ILLEGAL_CNT
);

   typedef enum logic [1:0] {StWaitKrn, StRun, StDrain} state_e;

   state_e         state_q, state_d;
   logic           cv_q, cv_d;
   logic [4:0]     cmd_q, cmd_d;
   logic [127:0]   key_q, key_d;
   logic [127:0]   msk_q, msk_d;
   logic [6:0]     pri_q, pri_d;
   logic [31:0]    val_q, val_d;
   logic [7:0]     out_q, out_d;
   logic           unf_q, unf_d;
   logic [8:0]     occ;
   logic           req_ready;
   logic           flush_done;
   logic           krn_drop;
   logic           accept;
   logic           legal;

   always_comb begin
      state_d    = state_q;
      cv_d       = 1'b0;
      cmd_d      = cmd_q;
      key_d      = key_q;
      msk_d      = msk_q;
      pri_d      = pri_q;
      val_d      = val_q;
      out_d      = out_q;
      unf_d      = unf_q;
      req_ready  = 1'b0;
      flush_done = 1'b0;
      krn_drop   = 1'b0;
      // Window occupancy includes the command sitting in the output register.
      occ        = {1'b0, out_q} + {8'd0, cv_q};

      unique case (state_q)
         StWaitKrn: begin
            if (I_KRN_READY && !I_KRN_WAIT) state_d = StRun;
         end
         StRun: begin
            // Also gated by I_KRN_READY so a request is never consumed in the cycle the kernel drops.
            req_ready = I_KRN_READY && !I_KRN_CMD_FULL && !I_KRN_WAIT && !I_FLUSH &&
                        (occ < 9'(MAX_OUTSTANDING));
            if (!I_KRN_READY) begin
               state_d  = StWaitKrn;
               krn_drop = 1'b1;
            end else if (I_FLUSH) begin
               state_d = StDrain;
            end
         end
         StDrain: begin
            if (!I_KRN_READY) begin
               state_d  = StWaitKrn;
               krn_drop = 1'b1;
            end else if (out_q == 8'd0 && !cv_q) begin
               flush_done = 1'b1;
               state_d    = StRun;
            end
         end
         default: state_d = StWaitKrn;
      endcase

      accept = I_REQ_VALID && req_ready;
      legal  = (I_REQ_OP <= 3'd4);

      if (accept && legal) begin
         cv_d  = 1'b1;
         key_d = I_REQ_KEY;
         msk_d = I_REQ_MSK;
         pri_d = I_REQ_PRI;
         val_d = I_REQ_VALUE;
         unique case (I_REQ_OP)
            3'd0:    cmd_d = 5'b00001;
            3'd1:    cmd_d = 5'b00010;
            3'd2:    cmd_d = 5'b00100;
            3'd3:    cmd_d = 5'b01000;
            default: cmd_d = 5'b10000;
         endcase
      end

      unique case ({cv_q, I_KRN_ACK})
         2'b10: out_d = out_q + 8'd1;
         2'b01: begin
            if (out_q == 8'd0) unf_d = 1'b1;
            else               out_d = out_q - 8'd1;
         end
         default: out_d = out_q;
      endcase

      // Kernel reset: everything in flight is lost on its side.
      if (krn_drop) begin
         out_d = 8'd0;
         cv_d  = 1'b0;
      end
   end

   always_ff @(posedge I_CLK) begin
      if (I_RST) begin
         state_q <= StWaitKrn;
         cv_q    <= 1'b0;
         cmd_q   <= 5'd0;
         key_q   <= 128'd0;
         msk_q   <= 128'd0;
         pri_q   <= 7'd0;
         val_q   <= 32'd0;
         out_q   <= 8'd0;
         unf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cv_q    <= cv_d;
         cmd_q   <= cmd_d;
         key_q   <= key_d;
         msk_q   <= msk_d;
         pri_q   <= pri_d;
         val_q   <= val_d;
         out_q   <= out_d;
         unf_q   <= unf_d;
      end
   end

   assign O_REQ_READY     = req_ready;
   assign O_FLUSH_DONE    = flush_done;
   assign O_CMD_VALID     = cv_q;
   assign O_CMD_ERASE     = cv_q & cmd_q[0];
   assign O_CMD_WRITE     = cv_q & cmd_q[1];
   assign O_CMD_READ      = cv_q & cmd_q[2];
   assign O_CMD_SEARCH    = cv_q & cmd_q[3];
   assign O_CMD_UPDATE    = cv_q & cmd_q[4];
   assign O_KEY_DAT       = key_q;
   assign O_EKEY_MSK      = msk_q;
   assign O_KEY_PRI       = pri_q;
   assign O_KEY_VALUE     = val_q;
   assign O_OUTSTANDING   = out_q;
   assign O_ACK_UNDERFLOW = unf_q;

`ifdef AXONERVE_KVS_ISSUER_STATS_EN
   logic [CNT_W-1:0] issue_cnt_q, issue_cnt_d;
   logic [CNT_W-1:0] ack_cnt_q, ack_cnt_d;
   logic [CNT_W-1:0] ill_cnt_q, ill_cnt_d;

   always_comb begin
      issue_cnt_d = issue_cnt_q + CNT_W'(cv_q);
      ack_cnt_d   = ack_cnt_q + CNT_W'(I_KRN_ACK);
      ill_cnt_d   = ill_cnt_q + CNT_W'(accept && !legal);
   end

   always_ff @(posedge I_CLK) begin
      if (I_RST) begin
         issue_cnt_q <= '0;
         ack_cnt_q   <= '0;
         ill_cnt_q   <= '0;
      end else begin
         issue_cnt_q <= issue_cnt_d;
         ack_cnt_q   <= ack_cnt_d;
         ill_cnt_q   <= ill_cnt_d;
      end
   end

   assign O_ISSUE_CNT   = issue_cnt_q;
   assign O_ACK_CNT     = ack_cnt_q;
   assign O_ILLEGAL_CNT = ill_cnt_q;
`else
   assign O_ISSUE_CNT   = '0;
   assign O_ACK_CNT     = '0;
   assign O_ILLEGAL_CNT = '0;
`endif

endmodule

// File: tb/tb_axonerve_kvs_cmd_issuer.sv
// Directed bench for axonerve_kvs_cmd_issuer with a command scoreboard; window of 4.
// Statistics expectations follow AXONERVE_KVS_ISSUER_STATS_EN.
module tb_axonerve_kvs_cmd_issuer;

   localparam int unsigned Max = 4;
`ifdef AXONERVE_KVS_ISSUER_STATS_EN
   localparam bit StatsEn = 1'b1;
`else
   localparam bit StatsEn = 1'b0;
`endif

   logic         I_CLK = 1'b0;
   logic         I_RST;
   logic         I_REQ_VALID;
   logic         O_REQ_READY;
   logic [2:0]   I_REQ_OP;
   logic [127:0] I_REQ_KEY;
   logic [127:0] I_REQ_MSK;
   logic [6:0]   I_REQ_PRI;
   logic [31:0]  I_REQ_VALUE;
   logic         I_FLUSH;
   logic         O_FLUSH_DONE;
   logic         I_KRN_READY;
   logic         I_KRN_WAIT;
   logic         I_KRN_CMD_FULL;
   logic         I_KRN_ACK;
   logic         O_CMD_VALID;
   logic         O_CMD_ERASE;
   logic         O_CMD_WRITE;
   logic         O_CMD_READ;
   logic         O_CMD_SEARCH;
   logic         O_CMD_UPDATE;
   logic [127:0] O_KEY_DAT;
   logic [127:0] O_EKEY_MSK;
   logic [6:0]   O_KEY_PRI;
   logic [31:0]  O_KEY_VALUE;
   logic [7:0]   O_OUTSTANDING;
   logic         O_ACK_UNDERFLOW;
   logic [31:0]  O_ISSUE_CNT;
   logic [31:0]  O_ACK_CNT;
   logic [31:0]  O_ILLEGAL_CNT;

   axonerve_kvs_cmd_issuer #(
      .MAX_OUTSTANDING(Max),
      .CNT_W          (32)
   ) dut (
      .I_CLK          (I_CLK),
      .I_RST          (I_RST),
      .I_REQ_VALID    (I_REQ_VALID),
      .O_REQ_READY    (O_REQ_READY),
      .I_REQ_OP       (I_REQ_OP),
      .I_REQ_KEY      (I_REQ_KEY),
      .I_REQ_MSK      (I_REQ_MSK),
      .I_REQ_PRI      (I_REQ_PRI),
      .I_REQ_VALUE    (I_REQ_VALUE),
      .I_FLUSH        (I_FLUSH),
      .O_FLUSH_DONE   (O_FLUSH_DONE),
      .I_KRN_READY    (I_KRN_READY),
      .I_KRN_WAIT     (I_KRN_WAIT),
      .I_KRN_CMD_FULL (I_KRN_CMD_FULL),
      .I_KRN_ACK      (I_KRN_ACK),
      .O_CMD_VALID    (O_CMD_VALID),
      .O_CMD_ERASE    (O_CMD_ERASE),
      .O_CMD_WRITE    (O_CMD_WRITE),
      .O_CMD_READ     (O_CMD_READ),
      .O_CMD_SEARCH   (O_CMD_SEARCH),
      .O_CMD_UPDATE   (O_CMD_UPDATE),
      .O_KEY_DAT      (O_KEY_DAT),
      .O_EKEY_MSK     (O_EKEY_MSK),
      .O_KEY_PRI      (O_KEY_PRI),
      .O_KEY_VALUE    (O_KEY_VALUE),
      .O_OUTSTANDING  (O_OUTSTANDING),
      .O_ACK_UNDERFLOW(O_ACK_UNDERFLOW),
      .O_ISSUE_CNT    (O_ISSUE_CNT),
      .O_ACK_CNT      (O_ACK_CNT),
      .O_ILLEGAL_CNT  (O_ILLEGAL_CNT)
   );

   always #5 I_CLK = ~I_CLK;

   typedef struct packed {
      logic [4:0]   cmd;
      logic [127:0] key;
      logic [127:0] msk;
      logic [6:0]   pri;
      logic [31:0]  val;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   checks   = 0;
   int   errors   = 0;
   int   fd_cnt   = 0;
   int   n_issue  = 0;
   int   n_ill    = 0;
   int   n_ack    = 0;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Negedge monitor: check issued commands, then log this cycle's handshake.
   always @(negedge I_CLK) begin
      if (!I_RST) begin
         if (O_CMD_VALID) begin
            chk("cmd_expected", 128'(sb.size() != 0), 128'd1);
            if (sb.size() != 0) begin
               e = sb.pop_front();
               chk("cmd_strobe", 128'({O_CMD_UPDATE, O_CMD_SEARCH, O_CMD_READ, O_CMD_WRITE,
                                       O_CMD_ERASE}), 128'(e.cmd));
               chk("cmd_key", O_KEY_DAT, e.key);
               chk("cmd_msk", O_EKEY_MSK, e.msk);
               chk("cmd_pri", 128'(O_KEY_PRI), 128'(e.pri));
               chk("cmd_val", 128'(O_KEY_VALUE), 128'(e.val));
            end
         end else begin
            chk("strobe_idle", 128'({O_CMD_UPDATE, O_CMD_SEARCH, O_CMD_READ, O_CMD_WRITE,
                                     O_CMD_ERASE}), 128'd0);
         end
         if (O_FLUSH_DONE) fd_cnt++;
         if (I_REQ_VALID && O_REQ_READY) begin
            if (I_REQ_OP <= 3'd4) begin
               sb.push_back('{cmd: 5'b00001 << I_REQ_OP, key: I_REQ_KEY, msk: I_REQ_MSK,
                              pri: I_REQ_PRI, val: I_REQ_VALUE});
               n_issue++;
            end else begin
               n_ill++;
            end
         end
      end
   end

   task automatic tick(output bit acc);
      #1;
      acc = I_REQ_VALID && O_REQ_READY;
      @(posedge I_CLK);
      #1;
   endtask

   task automatic step();
      bit a;
      tick(a);
   endtask

   task automatic send(input logic [2:0] op, input logic [127:0] key, input logic [31:0] val);
      bit acc;
      acc         = 1'b0;
      I_REQ_VALID = 1'b1;
      I_REQ_OP    = op;
      I_REQ_KEY   = key;
      I_REQ_MSK   = ~key;
      I_REQ_PRI   = key[6:0] ^ 7'h2a;
      I_REQ_VALUE = val;
      for (int c = 0; c < 20 && !acc; c++) tick(acc);
      I_REQ_VALID = 1'b0;
      chk("send_accept", 128'(acc), 128'd1);
   endtask

   task automatic ack_pulse();
      I_KRN_ACK = 1'b1;
      n_ack++;
      step();
      I_KRN_ACK = 1'b0;
   endtask

   initial begin
      int idx;
      bit acc;
      I_RST = 1'b1;
      I_REQ_VALID = 1'b0;
      I_REQ_OP = 3'd0;
      I_REQ_KEY = '0;
      I_REQ_MSK = '0;
      I_REQ_PRI = '0;
      I_REQ_VALUE = '0;
      I_FLUSH = 1'b0;
      I_KRN_READY = 1'b0;
      I_KRN_WAIT = 1'b0;
      I_KRN_CMD_FULL = 1'b0;
      I_KRN_ACK = 1'b0;
      repeat (3) step();
      chk("rst_ready", 128'(O_REQ_READY), 128'd0);
      chk("rst_cv", 128'(O_CMD_VALID), 128'd0);
      chk("rst_key", O_KEY_DAT, 128'd0);
      chk("rst_val", 128'(O_KEY_VALUE), 128'd0);
      chk("rst_out", 128'(O_OUTSTANDING), 128'd0);
      chk("rst_unf", 128'(O_ACK_UNDERFLOW), 128'd0);
      chk("rst_fd", 128'(O_FLUSH_DONE), 128'd0);
      chk("rst_issue", 128'(O_ISSUE_CNT), 128'd0);
      I_RST = 1'b0;
      step();
      chk("wait_ready", 128'(O_REQ_READY), 128'd0);
      I_KRN_READY = 1'b1;
      #1 chk("wait_ready_flags", 128'(O_REQ_READY), 128'd0);
      step();
      chk("run_ready", 128'(O_REQ_READY), 128'd1);

      // Six back-to-back searches into a window of four.
      idx = 0;
      I_REQ_OP = 3'd3;
      I_REQ_VALID = 1'b1;
      for (int c = 0; c < 12 && idx < 6; c++) begin
         I_REQ_KEY = 128'(idx + 16'h100);
         I_REQ_MSK = 128'(idx);
         I_REQ_PRI = 7'(idx);
         I_REQ_VALUE = 32'(idx * 3);
         tick(acc);
         if (acc) idx++;
      end
      chk("win_accepts", 128'(idx), 128'd4);
      chk("win_ready", 128'(O_REQ_READY), 128'd0);
      chk("win_out", 128'(O_OUTSTANDING), 128'(Max));
      ack_pulse();
      for (int c = 0; c < 6 && idx < 6; c++) begin
         I_REQ_KEY = 128'(idx + 16'h100);
         I_REQ_MSK = 128'(idx);
         I_REQ_PRI = 7'(idx);
         I_REQ_VALUE = 32'(idx * 3);
         tick(acc);
         if (acc) idx++;
      end
      I_REQ_VALID = 1'b0;
      chk("win_accepts_ack", 128'(idx), 128'd5);
      chk("win_out_ack", 128'(O_OUTSTANDING), 128'(Max));
      chk("win_ready_ack", 128'(O_REQ_READY), 128'd0);
      repeat (4) ack_pulse();
      chk("win_drained", 128'(O_OUTSTANDING), 128'd0);

      // Write then illegal op.
      send(3'd1, 128'h1234, 32'hCAFE);
      chk("wr_cv", 128'(O_CMD_VALID), 128'd1);
      chk("wr_strobe", 128'(O_CMD_WRITE), 128'd1);
      chk("wr_key", O_KEY_DAT, 128'h1234);
      chk("wr_val", 128'(O_KEY_VALUE), 128'hCAFE);
      step();
      chk("wr_cv_off", 128'(O_CMD_VALID), 128'd0);
      chk("wr_key_hold", O_KEY_DAT, 128'h1234);
      send(3'd6, 128'h9999, 32'h5555);
      chk("ill_cv", 128'(O_CMD_VALID), 128'd0);
      chk("ill_key_hold", O_KEY_DAT, 128'h1234);
      chk("ill_cnt", 128'(O_ILLEGAL_CNT), StatsEn ? 128'd1 : 128'd0);
      ack_pulse();
      chk("ill_out", 128'(O_OUTSTANDING), 128'd0);

      // Issue and ACK in the same cycle at occupancy 2, then underflow.
      send(3'd0, 128'hA0, 32'h1);
      send(3'd2, 128'hA1, 32'h2);
      step();
      chk("same_pre", 128'(O_OUTSTANDING), 128'd2);
      send(3'd4, 128'hA2, 32'h3);
      chk("same_cv", 128'(O_CMD_VALID), 128'd1);
      ack_pulse();
      chk("same_out", 128'(O_OUTSTANDING), 128'd2);
      repeat (2) ack_pulse();
      chk("same_drained", 128'(O_OUTSTANDING), 128'd0);
      chk("unf_clear", 128'(O_ACK_UNDERFLOW), 128'd0);
      ack_pulse();
      chk("unf_set", 128'(O_ACK_UNDERFLOW), 128'd1);
      chk("unf_out", 128'(O_OUTSTANDING), 128'd0);
      repeat (2) step();
      chk("unf_sticky", 128'(O_ACK_UNDERFLOW), 128'd1);

      // Flush with three outstanding.
      send(3'd3, 128'hB0, 32'h10);
      send(3'd3, 128'hB1, 32'h11);
      send(3'd3, 128'hB2, 32'h12);
      step();
      chk("fl_out", 128'(O_OUTSTANDING), 128'd3);
      I_FLUSH = 1'b1;
      #1 chk("fl_ready_same", 128'(O_REQ_READY), 128'd0);
      step();
      I_FLUSH = 1'b0;
      #1 chk("fl_ready_drain", 128'(O_REQ_READY), 128'd0);
      ack_pulse();
      chk("fl_fd_ack1", 128'(O_FLUSH_DONE), 128'd0);
      ack_pulse();
      chk("fl_fd_ack2", 128'(O_FLUSH_DONE), 128'd0);
      ack_pulse();
      chk("fl_fd_ack3", 128'(O_FLUSH_DONE), 128'd1);
      step();
      chk("fl_fd_off", 128'(O_FLUSH_DONE), 128'd0);
      chk("fl_resume", 128'(O_REQ_READY), 128'd1);
      chk("fl_pulses", 128'(fd_cnt), 128'd1);

      // Kernel drop mid-drain.
      send(3'd1, 128'hC0, 32'h20);
      send(3'd1, 128'hC1, 32'h21);
      I_FLUSH = 1'b1;
      step();
      I_FLUSH = 1'b0;
      I_KRN_READY = 1'b0;
      step();
      chk("drop_out", 128'(O_OUTSTANDING), 128'd0);
      chk("drop_cv", 128'(O_CMD_VALID), 128'd0);
      chk("drop_ready", 128'(O_REQ_READY), 128'd0);
      step();
      chk("drop_fd", 128'(O_FLUSH_DONE), 128'd0);
      I_KRN_READY = 1'b1;
      step();
      chk("drop_resume", 128'(O_REQ_READY), 128'd1);
      chk("drop_pulses", 128'(fd_cnt), 128'd1);

      // Programmable full blocks in the same cycle.
      I_KRN_CMD_FULL = 1'b1;
      #1 chk("full_ready", 128'(O_REQ_READY), 128'd0);
      I_KRN_CMD_FULL = 1'b0;
      #1 chk("full_release", 128'(O_REQ_READY), 128'd1);

      repeat (3) step();
      chk("sb_empty", 128'(sb.size()), 128'd0);
      chk("cnt_issue", 128'(O_ISSUE_CNT), StatsEn ? 128'(n_issue) : 128'd0);
      chk("cnt_ack", 128'(O_ACK_CNT), StatsEn ? 128'(n_ack) : 128'd0);
      chk("cnt_ill", 128'(O_ILLEGAL_CNT), StatsEn ? 128'(n_ill) : 128'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/axonerve_kvs_cmd_issuer.md
# axonerve_kvs_cmd_issuer

Request-side front end for the AXONERVE KVS kernel: accepts opcode-tagged key/value requests over a valid/ready handshake, decodes them into the kernel's one-hot command strobes, and issues at most one command per cycle. Issue is throttled by kernel readiness, command-FIFO fullness and an outstanding-command window closed by the kernel's ACK pulses. Sits directly upstream of the KVS kernel, between the host register/stream adapter and the kernel's I_CMD_* inputs.

## Interface
- MAX_OUTSTANDING, 16: maximum issued-but-unacknowledged commands (1..255).
- CNT_W, 32: width of the statistics counters.
- I_CLK  in  1  sole clock.
- I_RST  in  1  synchronous, active-high reset.
- I_REQ_VALID  in  1  request valid.
- O_REQ_READY  out  1  request accepted when I_REQ_VALID && O_REQ_READY.
- I_REQ_OP  in  3  0=erase, 1=write, 2=read, 3=search, 4=update, 5..7 illegal.
- I_REQ_KEY / I_REQ_MSK  in  128 each  key data / enable-key mask.
- I_REQ_PRI  in  7  key priority.
- I_REQ_VALUE  in  32  value.
- I_FLUSH  in  1  drain request (pulse).
- O_FLUSH_DONE  out  1  one-cycle pulse when a drain completes.
- I_KRN_READY, I_KRN_WAIT, I_KRN_CMD_FULL, I_KRN_ACK  in  1 each  kernel O_READY, O_WAIT, O_CMD_FULL, O_ACK.
- O_CMD_VALID  out  1  command strobe to kernel.
- O_CMD_ERASE / O_CMD_WRITE / O_CMD_READ / O_CMD_SEARCH / O_CMD_UPDATE  out  1 each  one-hot, qualified by O_CMD_VALID.
- O_KEY_DAT, O_EKEY_MSK  out  128 each; O_KEY_PRI  out  7; O_KEY_VALUE  out  32.
- O_OUTSTANDING  out  8  current window occupancy.
- O_ACK_UNDERFLOW  out  1  sticky: ACK received with zero outstanding.
- O_ISSUE_CNT, O_ACK_CNT, O_ILLEGAL_CNT  out  CNT_W each  statistics.

## Operation
- States: WAIT_KRN, RUN, DRAIN.
- WAIT_KRN: entered on reset; O_REQ_READY=0; go to RUN when I_KRN_READY=1 && I_KRN_WAIT=0.
- RUN: O_REQ_READY = !I_KRN_CMD_FULL && !I_KRN_WAIT && (outstanding + O_CMD_VALID) < MAX_OUTSTANDING && !I_FLUSH.
- Accepted legal op: registered onto O_CMD_* / O_KEY_* with exactly one strobe set; O_CMD_VALID high for one cycle per accepted request.
- Accepted illegal op (5..7): consumed, not issued, O_ILLEGAL_CNT += 1; O_CMD_VALID stays 0.
- Outstanding: +1 on each cycle O_CMD_VALID=1, -1 on each I_KRN_ACK=1; both in the same cycle -> unchanged. ACK at zero -> counter stays 0, O_ACK_UNDERFLOW set until reset.
- I_FLUSH in RUN -> DRAIN: O_REQ_READY=0; when outstanding==0 and O_CMD_VALID==0, pulse O_FLUSH_DONE, return to RUN. I_FLUSH in DRAIN or WAIT_KRN ignored.
- I_KRN_READY falling in RUN or DRAIN (kernel reset): go to WAIT_KRN, outstanding cleared to 0, O_CMD_VALID forced 0 next cycle, no O_FLUSH_DONE; pending drain is abandoned.
- Data outputs hold last issued values while O_CMD_VALID=0.

## Timing
- Reset values: O_REQ_READY 0, O_CMD_VALID and all strobes 0, O_KEY_* 0, O_OUTSTANDING 0, O_ACK_UNDERFLOW 0, O_FLUSH_DONE 0, all counters 0; state WAIT_KRN.
- Accept at edge N -> O_CMD_VALID and fields valid in cycle N+1 (1-cycle latency); O_OUTSTANDING reflects it from N+2.
- O_REQ_READY is combinational from state, kernel flags and registered occupancy; no combinational path from I_REQ_VALID to O_REQ_READY.
- Full throughput: one command per cycle while unthrottled. I_KRN_CMD_FULL (programmable full) deasserts O_REQ_READY in the same cycle; at most one further command lands in the FIFO.
- Window: occupancy never exceeds MAX_OUTSTANDING, counting the command in the output register.
- Statistics counters wrap modulo 2^CNT_W.

## Configuration
- AXONERVE_KVS_ISSUER_STATS_EN defined: O_ISSUE_CNT (+1 per O_CMD_VALID), O_ACK_CNT (+1 per I_KRN_ACK) and O_ILLEGAL_CNT are implemented.
- Undefined: the three counters are not built and their outputs are tied to 0; O_ACK_UNDERFLOW and all other behaviour are unchanged.

## Test plan
- Reset, then I_KRN_READY=1, I_KRN_WAIT=0 -> RUN; O_REQ_READY=1 one cycle after the flags are seen; all outputs 0 before that.
- MAX_OUTSTANDING=4, 6 back-to-back searches, no ACK -> 4 O_CMD_VALID pulses, O_REQ_READY=0, O_OUTSTANDING=4; single ACK -> fifth issued, occupancy stays 4.
- Write key 0x1234 value 0xCAFE -> next cycle O_CMD_WRITE=1, O_KEY_DAT=0x1234, O_KEY_VALUE=0xCAFE; op=6 -> no issue, O_ILLEGAL_CNT=1.
- Issue and ACK in the same cycle at occupancy 2 -> remains 2; ACK at occupancy 0 -> O_ACK_UNDERFLOW=1 and stays set.
- 3 outstanding, I_FLUSH pulse -> O_REQ_READY=0; O_FLUSH_DONE pulses exactly once, the cycle after the third ACK; RUN resumes.
- Mid-drain I_KRN_READY=0 -> WAIT_KRN, O_OUTSTANDING=0, no O_FLUSH_DONE; I_KRN_CMD_FULL=1 in RUN -> O_REQ_READY=0 in the same cycle.
